// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage write enables and bubble inserts for a
// 5-stage pipeline, with wait states for data-memory stalls and multi-cycle MDU ops.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mdu_start,
  input  logic        mdu_done,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_reg_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic        ex_mem_flush,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DMEM_WAIT, MDU_BUSY} state_e;

  // Control vector order: {pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f}
  localparam logic [6:0] CTL_RUN      = 7'b1101010;
  localparam logic [6:0] CTL_FREEZE   = 7'b0000000;
  localparam logic [6:0] CTL_MDU      = 7'b0000001;
  localparam logic [6:0] CTL_REDIRECT = 7'b1010110;
  localparam logic [6:0] CTL_LOADUSE  = 7'b0000110;
  localparam logic [6:0] CTL_IMEM     = 7'b0011010;
  localparam logic [6:0] CTL_RESET    = 7'b0010101;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [6:0]  ctl;
  logic        load_use;
  logic        eval_run;
  logic        start_ok;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Wait states decide first; RUN rules are shared by RUN and the DMEM_WAIT exit cycle.
  always_comb begin
    state_d  = state_q;
    ctl      = CTL_RUN;
    eval_run = 1'b0;
    start_ok = 1'b0;

    case (state_q)
      RUN: begin
        eval_run = 1'b1;
        start_ok = 1'b1;
      end
      DMEM_WAIT: begin
        if (!dmem_ready) begin
          ctl = CTL_FREEZE;
        end else begin
          eval_run = 1'b1;
          state_d  = RUN;
        end
      end
      MDU_BUSY: begin
        if (!mdu_done) begin
          ctl = CTL_MDU;
        end else begin
          ctl     = CTL_RUN;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (eval_run) begin
      if (dmem_req && !dmem_ready) begin
        ctl     = CTL_FREEZE;
        state_d = DMEM_WAIT;
      end else if (start_ok && mdu_start) begin
        ctl     = CTL_MDU;
        state_d = MDU_BUSY;
      end else if (ex_redirect) begin
        ctl = CTL_REDIRECT;
      end else if (load_use) begin
        ctl = CTL_LOADUSE;
      end else if (!imem_ready) begin
        ctl = CTL_IMEM;
      end
    end

    if (rst) begin
      ctl     = CTL_RESET;
      state_d = RUN;
    end
  end

  assign {pc_write, if_id_reg_write, if_id_flush, id_ex_write,
          id_ex_flush, ex_mem_write, ex_mem_flush} = ctl;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign stall_cycles = stall_cnt_q;

endmodule
